// File: rtl/conv_pkg.sv
// Shared types and helpers for the pointwise/expand convolution engine:
// FSM state encoding, size helpers and the output shift/ReLU/saturate rule.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_e;

    // Wide signed container for the biased sum so any WIDTH/GUARD fits.
    localparam int SAT_W = 64;

    // Beats accumulated per output pixel.
    function automatic int calc_k(input int kernel_dim, input int chin);
        return kernel_dim * kernel_dim * chin;
    endfunction

    // Pixels per layer.
    function automatic int calc_p(input int wout);
        return wout * wout;
    endfunction

    // Counter/index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator width: full product plus guard bits.
    function automatic int calc_acc_w(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    // Arithmetic right shift, optional ReLU, then clamp to a signed width-bit range.
    function automatic logic signed [SAT_W-1:0] shift_relu_sat(
        input logic signed [SAT_W-1:0] sum,
        input int                      frac_bits,
        input int                      width,
        input bit                      relu_en
    );
        logic signed [SAT_W-1:0] sh;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] res;
        sh = sum >>> frac_bits;
        hi = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
        lo = -(SAT_W'(1) <<< (width - 1));
        if (relu_en && sh[SAT_W-1]) begin
            res = '0;
        end else if (sh > hi) begin
            res = hi;
        end else if (sh < lo) begin
            res = lo;
        end else begin
            res = sh;
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_pw_lane.sv
// One output-channel lane: registered product, accumulator that reloads on the
// first beat of a pixel, and a registered bias/shift/ReLU/saturate result.
module conv_pw_lane
    import conv_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_W     = 38,
    parameter int FRAC_BITS = 14,
    parameter int RELU_EN   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [WIDTH-1:0]   ifm_p1_i,
    input  logic signed [WIDTH-1:0]   kern_p1_i,
    input  logic                      vld_p1_i,
    input  logic                      vld_p2_i,
    input  logic                      first_p2_i,
    input  logic                      out_en_i,
    input  logic signed [2*WIDTH-1:0] bias_i,
    output logic signed [WIDTH-1:0]   ofm_o
);

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0]    prod_p2_q;
    logic signed [ACC_W-1:0] acc_p3_q;
    logic signed [WIDTH-1:0] ofm_q;

    // S1 -> S2: full-precision signed product of the registered beat.
    always_ff @(posedge clk) begin
        if (vld_p1_i) begin
            prod_p2_q <= PW'(ifm_p1_i) * PW'(kern_p1_i);
        end
    end

    // S2 -> S3: first beat of a pixel reloads, so stale partial sums never leak.
    always_ff @(posedge clk) begin
        if (vld_p2_i) begin
            if (first_p2_i) begin
                acc_p3_q <= ACC_W'(prod_p2_q);
            end else begin
                acc_p3_q <= acc_p3_q + ACC_W'(prod_p2_q);
            end
        end
    end

    // S3 -> output: finished pixel gets bias, shift, ReLU and saturation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ofm_q <= '0;
        end else if (out_en_i) begin
            ofm_q <= WIDTH'(shift_relu_sat(SAT_W'(acc_p3_q) + SAT_W'(bias_i),
                                           FRAC_BITS, WIDTH, RELU_EN != 0));
        end
    end

    assign ofm_o = ofm_q;

endmodule

// File: rtl/conv_pw_engine.sv
// Pointwise/expand convolution engine: one streamed pixel beat is shared by
// DSP_NO MAC lanes, each fed its own kernel word from an external ROM.
// Start/done handshake, input stalling and a restartable layer FSM.
module conv_pw_engine
    import conv_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DSP_NO     = 192,
    parameter int CHIN       = 64,
    parameter int KERNEL_DIM = 1,
    parameter int WOUT       = 16,
    parameter int FRAC_BITS  = 14,
    parameter int RELU_EN    = 1,
    parameter int GUARD      = $clog2(KERNEL_DIM * KERNEL_DIM * CHIN)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic signed [WIDTH-1:0]                    ifm,
    input  logic                                       ifm_valid,
    output logic                                       ifm_ready,
    output logic [idx_w(calc_k(KERNEL_DIM, CHIN))-1:0] weight_addr,
    input  logic [DSP_NO*WIDTH-1:0]                    kernels,
    input  logic [DSP_NO*2*WIDTH-1:0]                  bias,
    output logic [DSP_NO*WIDTH-1:0]                    ofm,
    output logic                                       ofm_valid,
    output logic                                       busy,
    output logic                                       done,
    input  logic                                       ram_feedback,
    output logic                                       finish
);

    localparam int K     = calc_k(KERNEL_DIM, CHIN);
    localparam int P     = calc_p(WOUT);
    localparam int AW    = idx_w(K);
    localparam int PXW   = idx_w(P);
    localparam int ACC_W = calc_acc_w(WIDTH, GUARD);

    conv_state_e       state_q;
    logic              ifm_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              fb_seen_q;
    logic [AW-1:0]     waddr_q;
    logic [AW-1:0]     waddr_d;
    logic [PXW-1:0]    pix_q;

    logic              vld_p1_q;
    logic              first_p1_q;
    logic              last_p1_q;
    logic              vld_p2_q;
    logic              first_p2_q;
    logic              last_p2_q;
    logic              vld_p3_q;
    logic              last_p3_q;
    logic              ofm_valid_q;

    logic signed [WIDTH-1:0]  ifm_p1_q;
    logic [DSP_NO*WIDTH-1:0]  kern_p1_q;

    logic accept;
    logic last_beat;
    logic last_pix;
    logic pipe_empty;
    logic start_ok;
    logic lane_out_en;

    assign accept      = ifm_valid && ifm_ready_q;
    assign last_beat   = (waddr_q == AW'(K - 1));
    assign last_pix    = (pix_q == PXW'(P - 1));
    assign pipe_empty  = !(vld_p1_q || vld_p2_q || vld_p3_q);
    assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign waddr_d     = last_beat ? '0 : waddr_q + AW'(1);
    assign lane_out_en = vld_p3_q && last_p3_q;

    // Layer FSM with registered handshake outputs, beat/pixel counters and sticky feedback flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ifm_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fb_seen_q   <= 1'b0;
            waddr_q     <= '0;
            pix_q       <= '0;
        end else begin
            if (start_ok) begin
                fb_seen_q <= 1'b0;
            end else if (ram_feedback) begin
                fb_seen_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        ifm_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        waddr_q     <= '0;
                        pix_q       <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        waddr_q <= waddr_d;
                        if (last_beat) begin
                            if (last_pix) begin
                                state_q     <= ST_DRAIN;
                                ifm_ready_q <= 1'b0;
                                pix_q       <= '0;
                            end else begin
                                pix_q <= pix_q + PXW'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // The final pixel's pulse leaves the pipeline on the edge before this one.
                    if (pipe_empty) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    ifm_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    // Valid and first/last tags travel with the data through S1..S3 to the output pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q    <= 1'b0;
            first_p1_q  <= 1'b0;
            last_p1_q   <= 1'b0;
            vld_p2_q    <= 1'b0;
            first_p2_q  <= 1'b0;
            last_p2_q   <= 1'b0;
            vld_p3_q    <= 1'b0;
            last_p3_q   <= 1'b0;
            ofm_valid_q <= 1'b0;
        end else begin
            vld_p1_q    <= accept;
            first_p1_q  <= accept && (waddr_q == '0);
            last_p1_q   <= accept && last_beat;
            vld_p2_q    <= vld_p1_q;
            first_p2_q  <= first_p1_q;
            last_p2_q   <= last_p1_q;
            vld_p3_q    <= vld_p2_q;
            last_p3_q   <= last_p2_q;
            ofm_valid_q <= lane_out_en;
        end
    end

    // S1: capture the accepted beat together with the ROM word addressed for it.
    always_ff @(posedge clk) begin
        if (accept) begin
            ifm_p1_q  <= ifm;
            kern_p1_q <= kernels;
        end
    end

    for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
        conv_pw_lane #(
            .WIDTH     (WIDTH),
            .ACC_W     (ACC_W),
            .FRAC_BITS (FRAC_BITS),
            .RELU_EN   (RELU_EN)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .ifm_p1_i   (ifm_p1_q),
            .kern_p1_i  ($signed(kern_p1_q[g*WIDTH +: WIDTH])),
            .vld_p1_i   (vld_p1_q),
            .vld_p2_i   (vld_p2_q),
            .first_p2_i (first_p2_q),
            .out_en_i   (lane_out_en),
            .bias_i     ($signed(bias[g*2*WIDTH +: 2*WIDTH])),
            .ofm_o      (ofm[g*WIDTH +: WIDTH])
        );
    end

    assign ifm_ready   = ifm_ready_q;
    assign weight_addr = waddr_q;
    assign ofm_valid   = ofm_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign finish      = done_q && !fb_seen_q;

endmodule
